// File: rtl/mpx_pkg.sv
// Shared definitions for the stereo MPX encoder/decoder pair:
// demux FSM states, APB register word offsets and CTRL bit positions.
package mpx_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        WAIT_R   = 2'd1,
        WAIT_L   = 2'd2
    } state_t;

    // Word offsets as decoded from paddr[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PAIRS   = 2'd1;
    localparam logic [1:0] REG_DROPS   = 2'd2;
    localparam logic [1:0] REG_TIMEOUT = 2'd3;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_PILOT_SUB = 1;
    localparam int CTRL_SWAP      = 2;

endpackage

// File: rtl/mpx_demux_regs.sv
// APB register file for the stereo demux: CTRL and TIMEOUT storage plus the
// pair and saturating drop counters, both cleared by any write to their offset.
module mpx_demux_regs
    import mpx_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_DEFAULT = 16'd1024,
    parameter int          DROP_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    input  logic        pair_inc,
    input  logic        drop_inc,
    output logic        ctrl_enable,
    output logic        ctrl_pilot_sub,
    output logic        ctrl_swap,
    output logic [15:0] timeout
);

    logic [2:0]            ctrl;
    logic [31:0]           pairs;
    logic [DROP_WIDTH-1:0] drops;
    logic                  wr_en;
    logic [1:0]            reg_sel;
    logic                  unused_bits;

    assign wr_en       = psel & penable & pwrite;
    assign reg_sel     = paddr[3:2];
    assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[31:16]};

    assign ctrl_enable    = ctrl[CTRL_ENABLE];
    assign ctrl_pilot_sub = ctrl[CTRL_PILOT_SUB];
    assign ctrl_swap      = ctrl[CTRL_SWAP];

    // A clear landing in the same cycle as an increment takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            timeout <= TIMEOUT_DEFAULT;
            pairs   <= '0;
            drops   <= '0;
        end else begin
            if (wr_en && reg_sel == REG_CTRL)
                ctrl <= pwdata[2:0];
            if (wr_en && reg_sel == REG_TIMEOUT)
                timeout <= pwdata[15:0];

            if (wr_en && reg_sel == REG_PAIRS)
                pairs <= '0;
            else if (pair_inc)
                pairs <= pairs + 32'd1;

            if (wr_en && reg_sel == REG_DROPS)
                drops <= '0;
            else if (drop_inc && drops != {DROP_WIDTH{1'b1}})
                drops <= drops + DROP_WIDTH'(1);
        end
    end

    always_comb begin
        prdata = '0;
        if (psel) begin
            case (reg_sel)
                REG_CTRL:    prdata = {29'd0, ctrl};
                REG_PAIRS:   prdata = pairs;
                REG_DROPS:   prdata = 32'(drops);
                REG_TIMEOUT: prdata = {16'd0, timeout};
                default:     prdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/stereo_demux.sv
// Receive-side MPX demultiplexer: strips the pilot reference from each sample
// and pairs the alternating R/L stream into registered stereo outputs.
module stereo_demux
    import mpx_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_DEFAULT = 16'd1024,
    parameter int          DROP_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        penable,
    input  logic        psel,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    input  logic [15:0] mpx_in,
    input  logic        mpx_valid,
    input  logic [15:0] pilot_ref,
    input  logic        sync,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid
);

    logic        ctrl_enable;
    logic        ctrl_pilot_sub;
    logic        ctrl_swap;
    logic [15:0] timeout;
    state_t      state;
    logic [15:0] hold_r;
    logic [15:0] gap;
    logic [15:0] sample;
    logic [16:0] gap_next;
    logic        timeout_hit;
    logic        take_r;
    logic        emit_pair;
    logic        drop_evt;

    mpx_demux_regs #(
        .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT),
        .DROP_WIDTH      (DROP_WIDTH)
    ) u_regs (
        .clk            (clk),
        .reset          (reset),
        .psel           (psel),
        .penable        (penable),
        .paddr          (paddr),
        .pwrite         (pwrite),
        .pwdata         (pwdata),
        .prdata         (prdata),
        .pair_inc       (emit_pair),
        .drop_inc       (drop_evt),
        .ctrl_enable    (ctrl_enable),
        .ctrl_pilot_sub (ctrl_pilot_sub),
        .ctrl_swap      (ctrl_swap),
        .timeout        (timeout)
    );

    assign sample      = ctrl_pilot_sub ? (mpx_in - pilot_ref) : mpx_in;
    assign gap_next    = {1'b0, gap} + 17'd1;
    assign timeout_hit = (timeout != 16'd0) && (gap_next >= {1'b0, timeout});

    // sync realigns before the same-cycle sample is looked at, so that sample becomes R
    always_comb begin
        take_r    = 1'b0;
        emit_pair = 1'b0;
        drop_evt  = 1'b0;
        if (ctrl_enable) begin
            if (sync) begin
                drop_evt = (state == WAIT_L);
                take_r   = mpx_valid;
            end else begin
                case (state)
                    WAIT_R: take_r = mpx_valid;
                    WAIT_L: begin
                        if (mpx_valid)
                            emit_pair = 1'b1;
                        else if (timeout_hit)
                            drop_evt = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DISABLED;
            hold_r    <= '0;
            gap       <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= emit_pair;
            if (emit_pair) begin
                out_l <= ctrl_swap ? hold_r : sample;
                out_r <= ctrl_swap ? sample : hold_r;
            end

            if (!ctrl_enable) begin
                state <= DISABLED;
            end else if (take_r) begin
                hold_r <= sample;
                gap    <= '0;
                state  <= WAIT_L;
            end else if (emit_pair || drop_evt || sync) begin
                state <= WAIT_R;
            end else if (state == DISABLED) begin
                state <= WAIT_R;
            end else if (state == WAIT_L && gap != 16'hFFFF) begin
                gap <= gap + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stereo_demux.sv
// Self-checking bench for stereo_demux: directed steps plus randomized traffic,
// compared each cycle against a queue-based behavioural model of the demux.
module tb_stereo_demux;

    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        penable;
    logic        psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic [15:0] mpx_in;
    logic        mpx_valid;
    logic [15:0] pilot_ref;
    logic        sync;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_valid;

    always #5 clk = ~clk;

    stereo_demux #(
        .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT),
        .DROP_WIDTH      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .penable   (penable),
        .psel      (psel),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .mpx_in    (mpx_in),
        .mpx_valid (mpx_valid),
        .pilot_ref (pilot_ref),
        .sync      (sync),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending R samples waiting for their L partner
    logic [15:0] pend[$];
    logic [2:0]  m_ctrl;
    logic [15:0] m_timeout;
    logic [31:0] m_pairs;
    logic [31:0] m_drops;
    int          m_idle;
    bit          m_live;
    logic        m_valid;
    logic [15:0] m_l;
    logic [15:0] m_r;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic count_drop();
        if (m_drops < 32'h0000_FFFF)
            m_drops++;
    endtask

    task automatic model_step();
        logic [15:0] s;
        logic [15:0] r;
        m_valid = 1'b0;
        if (reset) begin
            pend.delete();
            m_ctrl    = '0;
            m_timeout = TIMEOUT_DEFAULT;
            m_pairs   = '0;
            m_drops   = '0;
            m_idle    = 0;
            m_live    = 1'b0;
            m_l       = '0;
            m_r       = '0;
            return;
        end
        s = m_ctrl[1] ? mpx_in - pilot_ref : mpx_in;
        if (!m_ctrl[0]) begin
            pend.delete();
            m_live = 1'b0;
        end else if (sync) begin
            if (pend.size() != 0)
                count_drop();
            pend.delete();
            m_live = 1'b1;
            if (mpx_valid) begin
                pend.push_back(s);
                m_idle = 0;
            end
        end else if (!m_live) begin
            m_live = 1'b1;
        end else if (mpx_valid) begin
            if (pend.size() == 0) begin
                pend.push_back(s);
                m_idle = 0;
            end else begin
                r       = pend.pop_front();
                m_valid = 1'b1;
                m_l     = m_ctrl[2] ? r : s;
                m_r     = m_ctrl[2] ? s : r;
                m_pairs++;
            end
        end else if (pend.size() != 0) begin
            m_idle++;
            if (m_timeout != 16'd0 && m_idle >= int'(m_timeout)) begin
                pend.delete();
                count_drop();
            end
        end
        if (psel && penable && pwrite) begin
            case (paddr[3:2])
                2'd0: m_ctrl    = pwdata[2:0];
                2'd1: m_pairs   = '0;
                2'd2: m_drops   = '0;
                2'd3: m_timeout = pwdata[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_output({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check_output({tag, ".l"}, 32'(out_l), 32'(m_l));
        check_output({tag, ".r"}, 32'(out_r), 32'(m_r));
    endtask

    task automatic apply_stimulus(input string tag, input logic v, input logic [15:0] d,
                                  input logic [15:0] p, input logic sy);
        mpx_valid = v;
        mpx_in    = d;
        pilot_ref = p;
        sync      = sy;
        tick(tag);
        mpx_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            tick(tag);
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel    = 1'b1;
        pwrite  = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwdata  = d;
        tick("apb_setup");
        penable = 1'b1;
        tick("apb_access");
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = a;
        #1;
        check_output(tag, prdata, exp);
        psel = 1'b0;
    endtask

    initial begin
        logic [31:0] val;
        reset     = 1'b1;
        penable   = 1'b0;
        psel      = 1'b0;
        paddr     = '0;
        pwrite    = 1'b0;
        pwdata    = '0;
        mpx_in    = '0;
        mpx_valid = 1'b0;
        pilot_ref = '0;
        sync      = 1'b0;

        idle("reset", 2);
        reset = 1'b0;
        apb_read("rst_ctrl", 32'h0, 32'h0);
        apb_read("rst_pairs", 32'h4, 32'h0);
        apb_read("rst_drops", 32'h8, 32'h0);
        apb_read("rst_timeout", 32'hC, 32'(TIMEOUT_DEFAULT));
        paddr = 32'hC;
        #1;
        check_output("prdata_nosel", prdata, 32'h0);

        $display("[TB] basic pair");
        apb_write(32'h0, 32'h1);
        idle("enable", 1);
        apply_stimulus("tp1_r", 1'b1, 16'h0100, 16'h0, 1'b0);
        apply_stimulus("tp1_l", 1'b1, 16'h0200, 16'h0, 1'b0);
        check_output("tp1_valid_c", 32'(out_valid), 32'h1);
        check_output("tp1_l_c", 32'(out_l), 32'h0200);
        check_output("tp1_r_c", 32'(out_r), 32'h0100);
        idle("tp1_after", 1);
        check_output("tp1_single", 32'(out_valid), 32'h0);
        apb_read("tp1_pairs", 32'h4, 32'h1);

        $display("[TB] pilot subtraction");
        apb_write(32'h0, 32'h3);
        apply_stimulus("tp2_r", 1'b1, 16'h0010, 16'h0010, 1'b0);
        apply_stimulus("tp2_l", 1'b1, 16'h8005, 16'h0010, 1'b0);
        check_output("tp2_l_c", 32'(out_l), 32'h7FF5);
        check_output("tp2_r_c", 32'(out_r), 32'h0000);

        $display("[TB] timeout");
        apb_write(32'hC, 32'h4);
        apply_stimulus("tp3_r", 1'b1, 16'h1234, 16'h0, 1'b0);
        idle("tp3_gap", 4);
        apb_read("tp3_drops", 32'h8, 32'h1);
        apply_stimulus("tp3_r2", 1'b1, 16'h0300, 16'h0, 1'b0);
        apply_stimulus("tp3_l2", 1'b1, 16'h0400, 16'h0, 1'b0);
        check_output("tp3_l_c", 32'(out_l), 32'h0400);
        check_output("tp3_r_c", 32'(out_r), 32'h0300);

        $display("[TB] sync realign");
        apb_write(32'h8, 32'h0);
        apply_stimulus("tp4_r", 1'b1, 16'h0A00, 16'h0, 1'b0);
        apply_stimulus("tp4_sync", 1'b1, 16'h0AAA, 16'h0, 1'b1);
        apply_stimulus("tp4_l", 1'b1, 16'h0BBB, 16'h0, 1'b0);
        check_output("tp4_l_c", 32'(out_l), 32'h0BBB);
        check_output("tp4_r_c", 32'(out_r), 32'h0AAA);
        apb_read("tp4_drops", 32'h8, 32'h1);

        $display("[TB] swap and pair clear");
        apb_write(32'h0, 32'h5);
        apply_stimulus("tp5_r", 1'b1, 16'h1111, 16'h0, 1'b0);
        apply_stimulus("tp5_l", 1'b1, 16'h2222, 16'h0, 1'b0);
        check_output("tp5_l_c", 32'(out_l), 32'h1111);
        check_output("tp5_r_c", 32'(out_r), 32'h2222);
        apb_write(32'h4, 32'h0);
        apb_read("tp5_pairs", 32'h4, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 49))
                0: begin
                    val = 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0)
                        val[0] = 1'b1;
                    apb_write(32'h0, val);
                end
                1: apb_write(32'hC, 32'($urandom_range(0, 6)));
                2: apb_write(32'h4, $urandom);
                3: apb_write(32'h8, $urandom);
                4: apb_read("rnd_pairs", 32'h4, m_pairs);
                5: apb_read("rnd_drops", 32'h8, m_drops);
                default: apply_stimulus("rnd", ($urandom_range(0, 2) != 0), 16'($urandom),
                                        16'($urandom), ($urandom_range(0, 19) == 0));
            endcase
        end
        apb_read("rnd_ctrl_end", 32'h0, 32'(m_ctrl));
        apb_read("rnd_timeout_end", 32'hC, 32'(m_timeout));
        apb_read("rnd_pairs_end", 32'h4, m_pairs);
        apb_read("rnd_drops_end", 32'h8, m_drops);

        $display("[TB] drop saturation");
        apb_write(32'hC, 32'h0);
        apb_write(32'h0, 32'h1);
        apb_write(32'h8, 32'h0);
        for (int i = 0; i < 65540; i++)
            apply_stimulus("sat", 1'b1, 16'($urandom), 16'h0, 1'b1);
        apb_read("sat_drops", 32'h8, 32'h0000_FFFF);
        apb_read("sat_drops_model", 32'h8, m_drops);

        $display("[TB] reset mid-pair");
        apply_stimulus("rm_r", 1'b1, 16'h5A5A, 16'h0, 1'b0);
        apply_stimulus("rm_l", 1'b1, 16'hA5A5, 16'h0, 1'b0);
        apply_stimulus("rm_r2", 1'b1, 16'h7777, 16'h0, 1'b0);
        reset     = 1'b1;
        mpx_valid = 1'b1;
        mpx_in    = 16'h6666;
        tick("rm_reset");
        reset     = 1'b0;
        mpx_valid = 1'b0;
        check_output("rm_valid_c", 32'(out_valid), 32'h0);
        check_output("rm_l_c", 32'(out_l), 32'h0);
        check_output("rm_r_c", 32'(out_r), 32'h0);
        idle("rm_after", 2);
        apb_read("rm_ctrl", 32'h0, 32'h0);
        apb_read("rm_pairs", 32'h4, 32'h0);
        apb_read("rm_drops", 32'h8, 32'h0);
        apb_read("rm_timeout", 32'hC, 32'(TIMEOUT_DEFAULT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
